// File: rtl/cond_logic.sv
// cond_logic: conditional-execution stage behind the ARM main/ALU decoder.
// Holds the NZCV flag register and checks the condition field against it.
// The decoder write strobes only reach the datapath when the condition passes.
// Optional build macro COND_STATS_EN adds two saturating counters,
// ExecCnt and SquashCnt, that count executed and squashed valid instructions.
module cond_logic #(
  parameter int FLAG_W = 4
`ifdef COND_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [3:0]        Cond,
  input  logic [FLAG_W-1:0] ALUFlags,
  input  logic [1:0]        FlagW,
  input  logic              PCS,
  input  logic              RegW,
  input  logic              MemW,
  input  logic              NoWrite,
  output logic              PCSrc,
  output logic              RegWrite,
  output logic              MemWrite,
  output logic              CondEx,
  output logic [FLAG_W-1:0] Flags,
  output logic              CondFailQ
`ifdef COND_STATS_EN
  , output logic [CNT_W-1:0] ExecCnt
  , output logic [CNT_W-1:0] SquashCnt
`endif
);

  logic flagN, flagZ, flagC, flagV;
  logic signedGe;
  logic execValid;

  assign flagN    = Flags[3];
  assign flagZ    = Flags[2];
  assign flagC    = Flags[1];
  assign flagV    = Flags[0];
  assign signedGe = (flagN == flagV);

  // Condition check uses the stored flags, never the ALU flags of this cycle.
  always_comb begin
    CondEx = 1'b0;
    unique case (Cond)
      4'b0000: CondEx = flagZ;
      4'b0001: CondEx = ~flagZ;
      4'b0010: CondEx = flagC;
      4'b0011: CondEx = ~flagC;
      4'b0100: CondEx = flagN;
      4'b0101: CondEx = ~flagN;
      4'b0110: CondEx = flagV;
      4'b0111: CondEx = ~flagV;
      4'b1000: CondEx = flagC & ~flagZ;
      4'b1001: CondEx = ~flagC | flagZ;
      4'b1010: CondEx = signedGe;
      4'b1011: CondEx = ~signedGe;
      4'b1100: CondEx = ~flagZ & signedGe;
      4'b1101: CondEx = flagZ | ~signedGe;
      4'b1110: CondEx = 1'b1;
      4'b1111: CondEx = 1'b0;   // reserved encoding never executes
      default: CondEx = 1'b0;
    endcase
  end

  assign execValid = en & CondEx;

  assign PCSrc    = execValid & PCS;
  assign RegWrite = execValid & RegW & ~NoWrite;
  assign MemWrite = execValid & MemW;

  // Flag register: the two halves update independently; a failed condition blocks both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Flags <= '0;
    end else begin
      if (execValid && FlagW[1]) Flags[3:2] <= ALUFlags[3:2];
      if (execValid && FlagW[0]) Flags[1:0] <= ALUFlags[1:0];
    end
  end

  // Remember whether the last valid instruction was squashed; bubbles leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      CondFailQ <= 1'b0;
    end else if (en) begin
      CondFailQ <= ~CondEx;
    end
  end

`ifdef COND_STATS_EN
  // Saturating counters of executed and squashed valid instructions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ExecCnt   <= '0;
      SquashCnt <= '0;
    end else if (en) begin
      if (CondEx) begin
        if (ExecCnt != {CNT_W{1'b1}}) ExecCnt <= ExecCnt + 1'b1;
      end else begin
        if (SquashCnt != {CNT_W{1'b1}}) SquashCnt <= SquashCnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: doc/cond_logic.md
Name: cond_logic

Overview:
- Conditional-execution stage directly downstream of the main/ALU decoder in the single-cycle ARM datapath.
- Holds the architectural NZCV flag register and evaluates the 4-bit condition field against the stored flags.
- Gates the decoder's RegW/MemW/PCS strobes into the final RegWrite/MemWrite/PCSrc that drive the register file, data memory and PC mux.
- Updates the flags from the ALU under FlagW control.

Parameters:
- FLAG_W, 4, width of the flag register (N,Z,C,V; bit 3 = N, bit 0 = V); fixed at 4, present for lint only.
- CNT_W, 16, width of the statistics counters (used only when COND_STATS_EN is defined).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  instruction valid / not stalled; 0 = bubble.
- Cond  input  4  instruction condition field, Instr[31:28].
- ALUFlags  input  4  {N,Z,C,V} from the ALU for the current instruction.
- FlagW  input  2  flag write enables from the ALU decoder; [1] = N,Z; [0] = C,V.
- PCS  input  1  PC-source request (branch, or write to R15).
- RegW  input  1  register-write request from the main decoder.
- MemW  input  1  memory-write request from the main decoder.
- NoWrite  input  1  compare-class instruction (CMP/CMN/TST/TEQ); suppresses the register write.
- PCSrc  output  1  gated PC-source select.
- RegWrite  output  1  gated register-file write enable.
- MemWrite  output  1  gated data-memory write enable.
- CondEx  output  1  condition passed for the current instruction.
- Flags  output  4  current registered {N,Z,C,V}.
- CondFailQ  output  1  registered: the last valid instruction was squashed.

Behaviour:
- Reset (rst_n=0, asynchronous): Flags=4'b0000, CondFailQ=0. Combinational outputs follow from these values.
- CondEx is combinational from the registered Flags (the pre-update value) and Cond:
  - 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C
  - 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V
  - 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V
  - 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 reserved 0 (never executes)
- Output gating, combinational, zero latency:
  - PCSrc = en & CondEx & PCS
  - RegWrite = en & CondEx & RegW & ~NoWrite
  - MemWrite = en & CondEx & MemW
- Flag update on the rising clk edge:
  - Flags[3:2] <= ALUFlags[3:2] iff en & CondEx & FlagW[1].
  - Flags[1:0] <= ALUFlags[1:0] iff en & CondEx & FlagW[0].
  - Otherwise hold.
  - The new flags are visible to the next instruction only; there is no same-cycle forwarding.
- CondFailQ <= en & ~CondEx on each edge when en=1. It holds when en=0.
- en=0: all gated outputs are 0, Flags hold, CondFailQ holds.
- A failed condition blocks both the flag write and all side effects, even if FlagW≠0.
- Reset asserted mid-instruction: Flags clear immediately. Any write in flight is lost. The gated outputs re-evaluate against 0000 (Z=0, so EQ fails and NE passes).

Optional Feature:
- Macro: COND_STATS_EN.
- Defined:
  - Adds outputs ExecCnt[CNT_W-1:0] and SquashCnt[CNT_W-1:0].
  - On each edge with en=1, ExecCnt increments if CondEx=1; otherwise SquashCnt increments.
  - Both saturate at all-ones and reset to 0 asynchronously.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
1. Reset, then Cond=1110, RegW=1, en=1 -> RegWrite=1, Flags=0000. Same instruction with Cond=0000 -> RegWrite=0, CondEx=0.
2. CMP model: Cond=1110, FlagW=11, NoWrite=1, RegW=1, ALUFlags=0100 -> RegWrite=0 that cycle; Flags=0100 after the edge. Next cycle, Cond=0000, PCS=1 -> PCSrc=1.
3. Partial write: Flags=0000, FlagW=10, ALUFlags=1111 -> Flags=1100 after the edge. Then FlagW=01, ALUFlags=0011 -> Flags=1111.
4. Squash: Flags=0100, Cond=0001 (NE), FlagW=11, MemW=1, ALUFlags=1010 -> MemWrite=0, Flags stay 0100, CondFailQ=1 after the edge.
5. Signed compares: Flags=1000 -> GE=0, LT=1, GT=0, LE=1. Flags=1001 -> GE=1, LT=0, GT=1, LE=0. Flags=0110 -> HI=0, LS=1. Cond=1111 always gives CondEx=0.
6. en=0 with Cond=1110, RegW=MemW=PCS=1, FlagW=11 -> all gated outputs 0, Flags unchanged. Assert rst_n low mid-cycle -> Flags=0000 before the next clk edge. With COND_STATS_EN: 3 passes and 2 fails -> ExecCnt=3, SquashCnt=2.
